// File: rtl/cnn_frame_loader.sv
// Streams an 8x8 frame into a buffer, kicks the CNN core, waits for its result
// and hands it downstream over valid/ready. One frame in flight at a time.
module cnn_frame_loader #(
   parameter int DATA_W  = 32,
   parameter int NPIX    = 64,
   parameter int TIMEOUT = 4096
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_W-1:0]        pix_data,
   input  logic                     pix_valid,
   input  logic                     pix_last,
   output logic                     pix_ready,
   output logic [NPIX*DATA_W-1:0]   img_flat,
   output logic                     core_enable,
   input  logic                     core_done,
   input  logic [DATA_W-1:0]        core_value,
   output logic [DATA_W-1:0]        res_data,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic                     err_frame,
   output logic                     err_timeout
);
   localparam int IDX_W = $clog2(NPIX);
   localparam int CNT_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_FILL, S_START, S_WAIT, S_OUT} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   res_data_q, res_data_d;
   logic                res_valid_q, res_valid_d;
   logic                err_frame_q, err_frame_d;
   logic                err_timeout_q, err_timeout_d;
   logic [DATA_W-1:0]   buf_q [NPIX];
   logic                pix_fire;

   assign pix_ready   = (state_q == S_FILL);
   assign core_enable = (state_q == S_START);
   assign pix_fire    = pix_valid & pix_ready;
   assign res_data    = res_data_q;
   assign res_valid   = res_valid_q;
   assign err_frame   = err_frame_q;
   assign err_timeout = err_timeout_q;

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      res_data_d    = res_data_q;
      res_valid_d   = res_valid_q;
      err_frame_d   = 1'b0;
      err_timeout_d = 1'b0;
      case (state_q)
         S_FILL: begin
            if (pix_fire) begin
               if (idx_q == IDX_W'(NPIX-1)) begin
                  // A full frame is used even when pix_last was missing.
                  idx_d       = '0;
                  state_d     = S_START;
                  err_frame_d = ~pix_last;
               end else if (pix_last) begin
                  idx_d       = '0;
                  err_frame_d = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (core_done) begin
               res_data_d  = core_value;
               res_valid_d = 1'b1;
               state_d     = S_OUT;
            end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
               err_timeout_d = 1'b1;
               state_d       = S_FILL;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_OUT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = S_FILL;
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_FILL;
         idx_q         <= '0;
         cnt_q         <= '0;
         res_data_q    <= '0;
         res_valid_q   <= 1'b0;
         err_frame_q   <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         res_data_q    <= res_data_d;
         res_valid_q   <= res_valid_d;
         err_frame_q   <= err_frame_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   // Buffer only changes in FILL, so img_flat is stable while the core works.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NPIX; i++) begin
            buf_q[i] <= '0;
         end
      end else if (pix_fire) begin
         buf_q[idx_q] <= pix_data;
      end
   end

   generate
      for (genvar gi = 0; gi < NPIX; gi++) begin : g_flat
         assign img_flat[gi*DATA_W +: DATA_W] = buf_q[gi];
      end
   endgenerate
endmodule

// File: tb/tb_cnn_frame_loader.sv
// Directed bench for cnn_frame_loader: inputs driven and outputs sampled on the
// falling edge; TIMEOUT shrunk to 16 so the abort path is reachable quickly.
module tb_cnn_frame_loader;
   localparam int DATA_W  = 32;
   localparam int NPIX    = 64;
   localparam int TIMEOUT = 16;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [DATA_W-1:0]      pix_data;
   logic                   pix_valid;
   logic                   pix_last;
   logic                   pix_ready;
   logic [NPIX*DATA_W-1:0] img_flat;
   logic                   core_enable;
   logic                   core_done;
   logic [DATA_W-1:0]      core_value;
   logic [DATA_W-1:0]      res_data;
   logic                   res_valid;
   logic                   res_ready;
   logic                   err_frame;
   logic                   err_timeout;

   int errors = 0;
   int checks = 0;
   int ce_cnt = 0;
   int ef_cnt = 0;

   cnn_frame_loader #(.DATA_W(DATA_W), .NPIX(NPIX), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_last(pix_last), .pix_ready(pix_ready),
      .img_flat(img_flat), .core_enable(core_enable),
      .core_done(core_done), .core_value(core_value),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .err_frame(err_frame), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (core_enable === 1'b1) ce_cnt++;
      if (err_frame === 1'b1) ef_cnt++;
   end

   function automatic logic [DATA_W-1:0] pix_at(input int i);
      return img_flat[i*DATA_W +: DATA_W];
   endfunction

   // Beats base+0 .. base+n-1; pix_last on beat last_pos (-1 = never).
   task automatic send_frame(input int n, input int last_pos, input logic [DATA_W-1:0] base);
      int stalls = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (pix_ready !== 1'b1) stalls++;
         pix_valid = 1'b1;
         pix_data  = base + DATA_W'(i);
         pix_last  = (i == last_pos);
      end
      @(negedge clk);
      pix_valid = 1'b0;
      pix_last  = 1'b0;
      checks++;
      if (stalls != 0) begin
         errors++;
         $display("FAIL beat_ready: stalled beats=%0d required 0", stalls);
      end
   endtask

   task automatic complete_core(input int delay, input logic [DATA_W-1:0] val);
      repeat (delay) @(negedge clk);
      core_done  = 1'b1;
      core_value = val;
      @(negedge clk);
      core_done  = 1'b0;
      core_value = '0;
      checks++;
      if (res_valid !== 1'b1 || res_data !== val) begin
         errors++;
         $display("FAIL result: res_valid=%b res_data=%h required 1 %h", res_valid, res_data, val);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; pix_valid = 0; pix_last = 0; pix_data = '0;
      core_done = 0; core_value = '0; res_ready = 1'b1;
      #12;
      checks++;
      if (pix_ready !== 1'b1 || core_enable !== 1'b0 || res_valid !== 1'b0 || res_data !== '0 ||
          err_frame !== 1'b0 || err_timeout !== 1'b0 || img_flat !== '0) begin
         errors++;
         $display("FAIL reset_state: rdy=%b ce=%b rv=%b rd=%h ef=%b et=%b flat_zero=%b required 1 0 0 0 0 0 1",
                  pix_ready, core_enable, res_valid, res_data, err_frame, err_timeout, img_flat == '0);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic_frame;
      int ce0 = ce_cnt;
      send_frame(64, 63, 32'd0);
      checks++;
      if (core_enable !== 1'b1 || pix_ready !== 1'b0) begin
         errors++;
         $display("FAIL basic_start: core_enable=%b pix_ready=%b required 1 0", core_enable, pix_ready);
      end
      checks++;
      if (pix_at(63) !== 32'd63 || pix_at(5) !== 32'd5) begin
         errors++;
         $display("FAIL basic_buffer: pix63=%0d pix5=%0d required 63 5", pix_at(63), pix_at(5));
      end
      complete_core(10, 32'h0000_0007);
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || pix_ready !== 1'b1 || ce_cnt != ce0 + 1) begin
         errors++;
         $display("FAIL basic_done: res_valid=%b pix_ready=%b enables=%0d required 0 1 1",
                  res_valid, pix_ready, ce_cnt - ce0);
      end
   endtask

   task automatic test_short_frame;
      int ce0 = ce_cnt;
      int ef0 = ef_cnt;
      send_frame(21, 20, 32'd100);
      checks++;
      if (err_frame !== 1'b1 || core_enable !== 1'b0 || pix_ready !== 1'b1) begin
         errors++;
         $display("FAIL short_err: err_frame=%b core_enable=%b pix_ready=%b required 1 0 1",
                  err_frame, core_enable, pix_ready);
      end
      send_frame(64, 63, 32'd200);
      checks++;
      if (core_enable !== 1'b1 || err_frame !== 1'b0 || pix_at(0) !== 32'd200 || pix_at(21) !== 32'd221) begin
         errors++;
         $display("FAIL short_next: ce=%b ef=%b pix0=%0d pix21=%0d required 1 0 200 221",
                  core_enable, err_frame, pix_at(0), pix_at(21));
      end
      complete_core(3, 32'h0000_0055);
      @(negedge clk);
      checks++;
      if (ce_cnt != ce0 + 1 || ef_cnt != ef0 + 1) begin
         errors++;
         $display("FAIL short_counts: enables=%0d err_frames=%0d required 1 1", ce_cnt - ce0, ef_cnt - ef0);
      end
   endtask

   task automatic test_missing_last;
      send_frame(64, -1, 32'd300);
      checks++;
      if (err_frame !== 1'b1 || core_enable !== 1'b1 || pix_at(63) !== 32'd363) begin
         errors++;
         $display("FAIL nolast: err_frame=%b core_enable=%b pix63=%0d required 1 1 363",
                  err_frame, core_enable, pix_at(63));
      end
      complete_core(2, 32'h0000_1234);
      @(negedge clk);
   endtask

   task automatic test_back_pressure;
      int unstable = 0;
      res_ready = 1'b0;
      send_frame(64, 63, 32'd400);
      complete_core(4, 32'hDEAD_BEEF);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (res_valid !== 1'b1 || res_data !== 32'hDEAD_BEEF || pix_ready !== 1'b0) unstable++;
      end
      checks++;
      if (unstable != 0) begin
         errors++;
         $display("FAIL stall_hold: unstable cycles=%0d required 0", unstable);
      end
      res_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || pix_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_release: res_valid=%b pix_ready=%b required 0 1", res_valid, pix_ready);
      end
   endtask

   task automatic test_timeout;
      int n = 0;
      int rv_seen = 0;
      logic seen = 1'b0;
      send_frame(64, 63, 32'd600);
      checks++;
      if (core_enable !== 1'b1) begin
         errors++;
         $display("FAIL to_start: core_enable=%b required 1", core_enable);
      end
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(negedge clk);
         if (res_valid !== 1'b0) rv_seen++;
         if (err_timeout === 1'b1) begin
            seen = 1'b1;
            n    = i;
         end
      end
      checks++;
      if (!seen || n != 17 || rv_seen != 0 || pix_ready !== 1'b1) begin
         errors++;
         $display("FAIL timeout: seen=%b cycles_after_enable=%0d res_valid_cycles=%0d pix_ready=%b required 1 17 0 1",
                  seen, n, rv_seen, pix_ready);
      end
      @(negedge clk);
      checks++;
      if (err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_pulse: err_timeout=%b required 0", err_timeout);
      end
   endtask

   task automatic test_async_reset;
      send_frame(30, -1, 32'd700);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (pix_ready !== 1'b1 || img_flat !== '0 || res_valid !== 1'b0 || core_enable !== 1'b0) begin
         errors++;
         $display("FAIL rst_fill: pix_ready=%b flat_zero=%b res_valid=%b ce=%b required 1 1 0 0",
                  pix_ready, img_flat == '0, res_valid, core_enable);
      end
      #1 rst_n = 1'b1;
      send_frame(64, 63, 32'd800);
      checks++;
      if (core_enable !== 1'b1 || pix_at(0) !== 32'd800 || pix_at(63) !== 32'd863) begin
         errors++;
         $display("FAIL rst_refill: ce=%b pix0=%0d pix63=%0d required 1 800 863",
                  core_enable, pix_at(0), pix_at(63));
      end
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (pix_ready !== 1'b1 || img_flat !== '0 || res_valid !== 1'b0 || err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL rst_wait: pix_ready=%b flat_zero=%b res_valid=%b et=%b required 1 1 0 0",
                  pix_ready, img_flat == '0, res_valid, err_timeout);
      end
      #1 rst_n = 1'b1;
      @(negedge clk);
      core_done = 1'b1; core_value = 32'h0000_0099;
      @(negedge clk);
      core_done = 1'b0;
      checks++;
      if (res_valid !== 1'b0) begin
         errors++;
         $display("FAIL stray_done: res_valid=%b required 0", res_valid);
      end
      send_frame(64, 63, 32'd900);
      checks++;
      if (pix_at(0) !== 32'd900 || core_enable !== 1'b1) begin
         errors++;
         $display("FAIL rst_next: pix0=%0d ce=%b required 900 1", pix_at(0), core_enable);
      end
      complete_core(1, 32'h0000_0042);
   endtask

   initial begin
      test_reset;
      test_basic_frame;
      test_short_frame;
      test_missing_last;
      test_back_pressure;
      test_timeout;
      test_async_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
